// File: rtl/ysyx_23060180_mem_slave.sv
// Byte-addressed on-chip RAM responder for the core's simple memory port.
// Write-first merge into the read snapshot, fixed-latency read pipeline.
module ysyx_23060180_mem_slave #(
    parameter logic [31:0] BASE_ADDR  = 32'h8000_0000,
    parameter int          SIZE_BYTES = 65536,
    parameter int          LATENCY    = 1
) (
    input  logic        clk,
    input  logic        rstn_in,
    input  logic        mem_rd,
    input  logic        mem_wr,
    input  logic [31:0] mem_raddr,
    input  logic [31:0] mem_wdata,
    input  logic [3:0]  mem_wbit_en,
    output logic [31:0] mem_rdata,
    output logic        mem_rvalid,
    output logic        mem_err
);

    localparam int AW = $clog2(SIZE_BYTES);

    logic [7:0]    mem [SIZE_BYTES];

    logic [31:0]   off;
    logic [3:0]    inr;
    logic [AW-1:0] idx [4];
    logic [3:0]    sel;
    logic          wlegal;
    logic [3:0]    we;
    logic          wr_err;
    logic          rd_err;
    logic [31:0]   snap;

    logic [LATENCY-1:0] pv;
    logic [31:0]        pd [LATENCY];

    assign off = mem_raddr - BASE_ADDR;

    // 33-bit compare so offsets near 2^32 cannot wrap back into range
    always_comb begin
        for (int k = 0; k < 4; k++) begin
            inr[k] = ({1'b0, off} + 33'(k)) < 33'(SIZE_BYTES);
            idx[k] = off[AW-1:0] + AW'(k);
        end
    end

    always_comb begin
        sel    = 4'b0000;
        wlegal = 1'b0;
        case (mem_wbit_en)
            4'd1: begin sel = 4'b0001; wlegal = 1'b1; end
            4'd2: begin sel = 4'b0011; wlegal = 1'b1; end
            4'd4: begin sel = 4'b1111; wlegal = 1'b1; end
            default: ;
        endcase
    end

    assign we     = mem_wr ? (sel & inr) : 4'b0000;
    assign wr_err = mem_wr & (~wlegal | (|(sel & ~inr)));
    assign rd_err = mem_rd & ~(&inr);

    // bytes written on this edge are forwarded into the read snapshot
    always_comb begin
        snap = 32'h0;
        for (int k = 0; k < 4; k++) begin
            if (!inr[k])
                snap[8*k +: 8] = 8'h00;
            else if (we[k])
                snap[8*k +: 8] = mem_wdata[8*k +: 8];
            else
                snap[8*k +: 8] = mem[idx[k]];
        end
    end

    always_ff @(posedge clk or negedge rstn_in) begin
        if (!rstn_in) begin
            pv      <= '0;
            mem_err <= 1'b0;
            for (int i = 0; i < LATENCY; i++)
                pd[i] <= 32'h0;
        end else begin
            for (int k = 0; k < 4; k++)
                if (we[k])
                    mem[idx[k]] <= mem_wdata[8*k +: 8];
            mem_err <= wr_err | rd_err;
            pv[0]   <= mem_rd;
            if (mem_rd)
                pd[0] <= snap;
            // data regs only advance with a valid so the output holds
            for (int i = 1; i < LATENCY; i++) begin
                pv[i] <= pv[i-1];
                if (pv[i-1])
                    pd[i] <= pd[i-1];
            end
        end
    end

    assign mem_rvalid = pv[LATENCY-1];
    assign mem_rdata  = pd[LATENCY-1];

endmodule

// File: tb/tb_ysyx_23060180_mem_slave.sv
// Directed bench for ysyx_23060180_mem_slave at LATENCY 1 and 3.
// Both instances share stimulus; each is checked where relevant.
module tb_ysyx_23060180_mem_slave;

    logic        clk;
    logic        rstn_in;
    logic        mem_rd;
    logic        mem_wr;
    logic [31:0] mem_raddr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wbit_en;

    logic [31:0] rdata1;
    logic        rvalid1;
    logic        err1;
    logic [31:0] rdata3;
    logic        rvalid3;
    logic        err3;

    int n_checks = 0;
    int n_fail   = 0;

    ysyx_23060180_mem_slave #(.LATENCY(1)) u_l1 (
        .clk(clk), .rstn_in(rstn_in),
        .mem_rd(mem_rd), .mem_wr(mem_wr),
        .mem_raddr(mem_raddr), .mem_wdata(mem_wdata),
        .mem_wbit_en(mem_wbit_en),
        .mem_rdata(rdata1), .mem_rvalid(rvalid1), .mem_err(err1)
    );

    ysyx_23060180_mem_slave #(.LATENCY(3)) u_l3 (
        .clk(clk), .rstn_in(rstn_in),
        .mem_rd(mem_rd), .mem_wr(mem_wr),
        .mem_raddr(mem_raddr), .mem_wdata(mem_wdata),
        .mem_wbit_en(mem_wbit_en),
        .mem_rdata(rdata3), .mem_rvalid(rvalid3), .mem_err(err3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag,
                         input logic [31:0] got,
                         input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got=%08h exp=%08h", tag, got, exp);
        end
    endtask

    // one edge, then settle just after it
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        mem_rd      = 1'b0;
        mem_wr      = 1'b0;
        mem_raddr   = 32'h0;
        mem_wdata   = 32'h0;
        mem_wbit_en = 4'd0;
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d,
                      input logic [3:0] n);
        idle();
        mem_wr      = 1'b1;
        mem_raddr   = a;
        mem_wdata   = d;
        mem_wbit_en = n;
    endtask

    task automatic rd(input logic [31:0] a);
        idle();
        mem_rd    = 1'b1;
        mem_raddr = a;
    endtask

    initial begin
        idle();
        rstn_in = 1'b0;
        #2;
        check("rst_rdata1", rdata1, 32'h0);
        check("rst_rvalid1", 32'(rvalid1), 32'h0);
        check("rst_err1", 32'(err1), 32'h0);
        check("rst_rvalid3", 32'(rvalid3), 32'h0);
        cyc();
        cyc();
        rstn_in = 1'b1;

        // word write then read
        wr(32'h8000_0000, 32'hDEAD_BEEF, 4'd4);
        cyc();
        check("w_word_err", 32'(err1), 32'h0);
        rd(32'h8000_0000);
        cyc();
        check("r_word_v", 32'(rvalid1), 32'h1);
        check("r_word_d", rdata1, 32'hDEAD_BEEF);
        idle();
        cyc();
        check("r_word_pulse", 32'(rvalid1), 32'h0);
        check("r_word_hold", rdata1, 32'hDEAD_BEEF);

        // sub-word writes
        wr(32'h8000_0001, 32'h0000_00AA, 4'd1);
        cyc();
        rd(32'h8000_0000);
        cyc();
        check("r_byte0", rdata1, 32'hDEAD_AAEF);
        rd(32'h8000_0001);
        cyc();
        check("r_unal1", rdata1, 32'h00DE_ADAA);
        wr(32'h8000_0002, 32'hFFFF_1234, 4'd2);
        cyc();
        rd(32'h8000_0000);
        cyc();
        check("r_half", rdata1, 32'h1234_AAEF);

        // errors and boundaries
        rd(32'h7FFF_FFFC);
        cyc();
        check("oor_rdata", rdata1, 32'h0);
        check("oor_rvalid", 32'(rvalid1), 32'h1);
        check("oor_err", 32'(err1), 32'h1);
        wr(32'h8000_0000, 32'h0, 4'd3);
        cyc();
        check("en3_err", 32'(err1), 32'h1);
        rd(32'h8000_0000);
        cyc();
        check("en3_nochg", rdata1, 32'h1234_AAEF);
        check("err_pulse", 32'(err1), 32'h0);
        wr(32'h8000_FFFE, 32'h0000_BEEF, 4'd2);
        cyc();
        check("top_half_err", 32'(err1), 32'h0);
        rd(32'h8000_FFFE);
        cyc();
        check("top_rd", rdata1, 32'h0000_BEEF);
        check("top_rd_err", 32'(err1), 32'h1);
        wr(32'h8000_FFFE, 32'h1122_3344, 4'd4);
        cyc();
        check("top_wr_err", 32'(err1), 32'h1);
        rd(32'h8000_FFFE);
        cyc();
        check("top_wr_part", rdata1, 32'h0000_3344);

        // simultaneous read and write
        wr(32'h8000_0010, 32'h55AA_55AA, 4'd4);
        mem_rd = 1'b1;
        cyc();
        check("rw_same_d", rdata1, 32'h55AA_55AA);
        check("rw_same_v", 32'(rvalid1), 32'h1);
        check("rw_same_err", 32'(err1), 32'h0);

        // LATENCY=3 back-to-back reads
        wr(32'h8000_0100, 32'd1, 4'd4);
        cyc();
        wr(32'h8000_0104, 32'd2, 4'd4);
        cyc();
        wr(32'h8000_0108, 32'd3, 4'd4);
        cyc();
        rd(32'h8000_0100);
        cyc();
        check("l3_t0_v", 32'(rvalid3), 32'h0);
        rd(32'h8000_0104);
        cyc();
        check("l3_t1_v", 32'(rvalid3), 32'h0);
        rd(32'h8000_0108);
        cyc();
        check("l3_d1_v", 32'(rvalid3), 32'h1);
        check("l3_d1", rdata3, 32'd1);
        idle();
        cyc();
        check("l3_d2_v", 32'(rvalid3), 32'h1);
        check("l3_d2", rdata3, 32'd2);
        cyc();
        check("l3_d3_v", 32'(rvalid3), 32'h1);
        check("l3_d3", rdata3, 32'd3);
        cyc();
        check("l3_end_v", 32'(rvalid3), 32'h0);

        // in-flight read not altered by later write
        rd(32'h8000_0100);
        cyc();
        wr(32'h8000_0100, 32'd9, 4'd4);
        cyc();
        idle();
        cyc();
        check("l3_iso_v", 32'(rvalid3), 32'h1);
        check("l3_iso_d", rdata3, 32'd1);
        rd(32'h8000_0100);
        cyc();
        idle();
        cyc();
        cyc();
        check("l3_new_d", rdata3, 32'd9);

        // reset with a read pending in the LATENCY=3 pipe
        rd(32'h8000_0104);
        cyc();
        idle();
        cyc();
        rstn_in = 1'b0;
        #1;
        check("mid_rst_v3", 32'(rvalid3), 32'h0);
        check("mid_rst_d3", rdata3, 32'h0);
        check("mid_rst_d1", rdata1, 32'h0);
        wr(32'h8000_0000, 32'hFFFF_FFFF, 4'd4);
        cyc();
        idle();
        rstn_in = 1'b1;
        for (int i = 0; i < 4; i++) begin
            cyc();
            check("post_rst_v3", 32'(rvalid3), 32'h0);
        end
        rd(32'h8000_0000);
        cyc();
        idle();
        check("rst_no_wr", rdata1, 32'h1234_AAEF);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/ysyx_23060180_mem_slave.md
# ysyx_23060180_mem_slave

Byte-addressed memory responder that sits on the far side of the CPU core's simple memory port (`mem_rd` / `mem_wr` / `mem_raddr` / `mem_wdata` / `mem_wbit_en` / `mem_rdata`). It serves instruction fetches, loads and stores with a fixed, parameterizable read latency. Write data is taken unshifted, and the write size comes as a byte count. It replaces the behavioural DPI memory in NPC simulation and is the synthesizable on-chip RAM model for later SoC integration.

## Interface
Parameters:
- `BASE_ADDR`, default `32'h8000_0000`: first byte address mapped.
- `SIZE_BYTES`, default `65536`: mapped size; must be a power of two, at least 4.
- `LATENCY`, default `1`: read latency in cycles; legal range 1..4. The core requires 1.

Ports:
- `clk`  in  1  clock.
- `rstn_in`  in  1  reset, asynchronous, active-low.
- `mem_rd`  in  1  read request, sampled every rising edge.
- `mem_wr`  in  1  write request, sampled every rising edge.
- `mem_raddr`  in  32  byte address for both reads and writes; any alignment.
- `mem_wdata`  in  32  write data; byte 0 of the store is `[7:0]`.
- `mem_wbit_en`  in  4  write size in bytes: 1 = byte, 2 = half, 4 = word; any other value is illegal.
- `mem_rdata`  out  32  read data; byte at `mem_raddr` appears in `[7:0]`, little-endian upward.
- `mem_rvalid`  out  1  one-cycle pulse marking a new `mem_rdata`.
- `mem_err`  out  1  one-cycle pulse on an out-of-range access or an illegal `mem_wbit_en`.

## Operation
- Storage is an array of `SIZE_BYTES` bytes. Offset `off = mem_raddr - BASE_ADDR`, unsigned 32-bit. Byte `k` of an access is in range iff `off + k < SIZE_BYTES`, computed without 32-bit wrap (use a 33-bit compare).
- Memory contents are not cleared by reset. Simulation initial contents are all zero.

Write, on an edge with `mem_wr=1`:
- If `mem_wbit_en` is 1, 2 or 4, write `mem_wdata` bytes 0..n-1 to offsets `off .. off+n-1`.
- Unaligned and word-crossing writes are legal.
- Out-of-range bytes are dropped. `mem_err` pulses if any byte was dropped.
- If `mem_wbit_en` is illegal, no byte is written and `mem_err` pulses.

Read, on an edge with `mem_rd=1`:
- Snapshot bytes `off .. off+3` into pipeline stage 1. Out-of-range bytes read as `8'h00`. `mem_err` pulses if any byte is out of range.
- A write committed later cannot alter a read that is already in flight.

Simultaneous `mem_rd` and `mem_wr` on one edge:
- Write-first: the read snapshot sees the newly written bytes.
- When both are illegal or out of range, `mem_err` is still a single pulse.

Read pipeline:
- `LATENCY` stages, each holding {valid, data}. Stage `LATENCY` drives `mem_rvalid` / `mem_rdata`.
- Accepts one read per cycle (full throughput); no backpressure.
- `mem_rdata` holds the last delivered value when `mem_rvalid=0`.

## Timing
- Reset values (asynchronous assert): `mem_rdata=0`, `mem_rvalid=0`, `mem_err=0`, all pipeline valid bits 0.
- Reset mid-operation: in-flight reads are discarded and never delivered. An edge occurring while `rstn_in=0` performs no write and no read.
- A read sampled at edge T gives `mem_rvalid=1` and valid `mem_rdata` during the cycle after edge T+LATENCY-1. With LATENCY=1 the data is visible the cycle directly after the request; the core latches it on its `mem_rd_d1` cycle.
- A write becomes visible to reads sampled at the same edge and at all later edges.
- `mem_err` is registered: it is high for the one cycle after the offending edge, independent of `LATENCY`.
- `mem_rd` held high for N consecutive edges produces exactly N `mem_rvalid` pulses, in order.

## Test plan
1. Assert `rstn_in=0` mid-stream, including during a pending read with LATENCY=3 -> outputs 0 immediately; the pending read is never delivered after release.
2. Word write then read (LATENCY=1):
   - Write `0xDEADBEEF` to `0x8000_0000` with en=4; next edge read `0x8000_0000`.
   - Expect `mem_rdata=0xDEADBEEF` with `mem_rvalid=1` for exactly one cycle, in the cycle after the read edge.
3. Sub-word writes from test 2's state:
   - Byte write `wdata=0x000000AA` to `0x8000_0001` (en=1); read `0x8000_0000` -> `0xDEADAAEF`; read `0x8000_0001` -> `[7:0]=0xAA`.
   - Half write `wdata=0xFFFF1234` to `0x8000_0002` (en=2); read `0x8000_0000` -> `0x1234AAEF`.
4. Error and boundary cases:
   - Read `0x7FFF_FFFC` -> `mem_rdata=0`, `mem_err` pulse.
   - Write with en=3 to `0x8000_0000` -> no change, `mem_err` pulse.
   - Word read at `BASE_ADDR+SIZE_BYTES-2` -> upper two bytes 0, `mem_err` pulse.
5. Same edge `mem_rd=1`, `mem_wr=1`, addr `0x8000_0010`, `wdata=0x55AA55AA`, en=4 -> delivered read `0x55AA55AA`.
6. LATENCY=3:
   - Reads to addresses holding 1, 2, 3 on consecutive edges, plus a write of 9 to the first address on the edge after the first read.
   - Expect `mem_rvalid` high for 3 consecutive cycles, data 1, 2, 3 (the first read is not altered to 9), first data in the cycle after edge T+2.
